// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU control path: opcodes, sequencer states, ALU codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_pkg;

  // Field widths of the instruction word and the datapath.
  localparam int CPU_DATA_W = 16;
  localparam int CPU_IR_W   = 9;
  localparam int OP_W       = 3;
  localparam int REG_W      = 3;
  localparam int NUM_REGS   = 8;

  // Opcodes held in ir[8:6].
  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;

  // Sequencer time steps.
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // ALU operation codes driven on alu_op.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // How an instruction walks through T1..T3.
  typedef enum logic [1:0] {
    CLS_MV  = 2'd0,  // register copy, retires in T1
    CLS_MVI = 2'd1,  // immediate load from din, retires in T1
    CLS_ALU = 2'd2,  // A <- rx, G <- A op ry, rx <- G; retires in T3
    CLS_NOP = 2'd3   // no writes, retires in T1
  } op_class_t;

  // One-hot register select from a 3-bit register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Instruction decoder: IR -> opcode class, one-hot/binary rx, ry, ALU operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows IR. CTRL_LOGIC_OPS_EN enables the and/xor opcodes.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_IR_W-1:0] ir,
  output op_class_t           op_class,
  output logic [NUM_REGS-1:0] rx_onehot,
  output logic [REG_W-1:0]    rx,
  output logic [REG_W-1:0]    ry,
  output logic [1:0]          alu_op
);

  logic [OP_W-1:0] opcode;

  assign opcode    = ir[8:6];
  assign rx        = ir[5:3];
  assign ry        = ir[2:0];
  assign rx_onehot = reg_onehot(ir[5:3]);

  // Classify the opcode and pick the ALU function for the arithmetic/logic path.
  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_MV:  op_class = CLS_MV;
      OP_MVI: op_class = CLS_MVI;
      OP_ADD: begin
        op_class = CLS_ALU;
        alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        op_class = CLS_ALU;
        alu_op   = ALU_SUB;
      end
`ifdef CTRL_LOGIC_OPS_EN
      OP_AND: begin
        op_class = CLS_ALU;
        alu_op   = ALU_AND;
      end
      OP_XOR: begin
        op_class = CLS_ALU;
        alu_op   = ALU_XOR;
      end
`else
      // Logic opcodes not built: they retire as NOPs and never reach the ALU.
      OP_AND, OP_XOR: begin
        op_class = CLS_NOP;
        alu_op   = ALU_ADD;
      end
`endif
      default: begin
        op_class = CLS_NOP;
        alu_op   = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch IR in T0, drive bus/reg/ALU controls through T1..T3, pulse done.
// Latency: run->done 2 cycles (mv/mvi/nop), 4 cycles (ALU ops); controls combinational from state+IR.
// Backpressure: none; run sampled only in T0. Macro CTRL_LOGIC_OPS_EN adds and/xor opcodes.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              ir_en,
  output logic [7:0]        r_in,
  output logic [2:0]        r_out,
  output logic              din_en,
  output logic              gout,
  output logic              a_in,
  output logic              g_in,
  output logic [1:0]        alu_op,
  output logic              done
);

  logic [1:0]          state;
  logic [IR_W-1:0]     ir;
  op_class_t           op_class;
  logic [NUM_REGS-1:0] rx_onehot;
  logic [REG_W-1:0]    rx;
  logic [REG_W-1:0]    ry;
  logic [1:0]          dec_alu_op;
  logic                unused_din_hi;

  // Only the low IR_W bits of din form an instruction; the rest is immediate data for the bus.
  assign unused_din_hi = ^din[DATA_W-1:IR_W];

  instr_decoder u_decoder (
    .ir        (ir),
    .op_class  (op_class),
    .rx_onehot (rx_onehot),
    .rx        (rx),
    .ry        (ry),
    .alu_op    (dec_alu_op)
  );

  // Sequencer state and instruction register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: begin
          if (run) begin
            ir    <= din[IR_W-1:0];
            state <= T1;
          end
        end
        T1:      state <= (op_class == CLS_ALU) ? T2 : T0;
        T2:      state <= T3;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  // Control outputs decoded from the current time step and instruction.
  always_comb begin
    ir_en  = 1'b0;
    r_in   = '0;
    r_out  = '0;
    din_en = 1'b0;
    gout   = 1'b0;
    a_in   = 1'b0;
    g_in   = 1'b0;
    alu_op = ALU_ADD;
    done   = 1'b0;
    case (state)
      T0: begin
        // Gated by resetn so run cannot leak through while the block is held in reset.
        ir_en = run & resetn;
      end
      T1: begin
        case (op_class)
          CLS_MV: begin
            r_out = ry;
            r_in  = rx_onehot;
            done  = 1'b1;
          end
          CLS_MVI: begin
            din_en = 1'b1;
            r_in   = rx_onehot;
            done   = 1'b1;
          end
          CLS_ALU: begin
            r_out = rx;
            a_in  = 1'b1;
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        r_out  = ry;
        g_in   = 1'b1;
        alu_op = dec_alu_op;
      end
      T3: begin
        gout = 1'b1;
        r_in = rx_onehot;
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed cases then random instruction streams against a reference model.
// A small datapath model is driven by the DUT controls to check register results end to end.
// CTRL_LOGIC_OPS_EN must be defined identically for bench and design.
module tb_control_unit;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_en;
  logic [7:0]  r_in;
  logic [2:0]  r_out;
  logic        din_en;
  logic        gout;
  logic        a_in;
  logic        g_in;
  logic [1:0]  alu_op;
  logic        done;

  int tests = 0;
  int fails = 0;

  // Datapath model driven by the DUT's controls.
  logic [15:0] dp_r [8];
  logic [15:0] dp_a;
  logic [15:0] dp_g;
  // Architectural register file computed from instruction semantics alone.
  logic [15:0] mref [8];

  logic [18:0] obs;

  control_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .ir_en  (ir_en),
    .r_in   (r_in),
    .r_out  (r_out),
    .din_en (din_en),
    .gout   (gout),
    .a_in   (a_in),
    .g_in   (g_in),
    .alu_op (alu_op),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {ir_en, r_in, r_out, din_en, gout, a_in, g_in, alu_op, done};

  function automatic logic [18:0] pack(input logic ie, input logic [7:0] ri, input logic [2:0] ro,
                                       input logic de, input logic go, input logic ai,
                                       input logic gi, input logic [1:0] ao, input logic dn);
    return {ie, ri, ro, de, go, ai, gi, ao, dn};
  endfunction

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_alu_op(input logic [2:0] op);
`ifdef CTRL_LOGIC_OPS_EN
    return (op >= 3'd2) && (op <= 3'd5);
`else
    return (op == 3'd2) || (op == 3'd3);
`endif
  endfunction

  function automatic int n_cycles(input logic [8:0] ins);
    return is_alu_op(ins[8:6]) ? 4 : 2;
  endfunction

  // Expected control word in cycle k of an instruction (k=0 is the fetch cycle with run=1).
  function automatic logic [18:0] expect_at(input logic [8:0] ins, input int k);
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] oh;
    logic [1:0] aop;
    op  = ins[8:6];
    rx  = ins[5:3];
    ry  = ins[2:0];
    oh  = 8'd1 << rx;
    aop = 2'(op - 3'd2);
    if (k == 0) return pack(1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    if (k == 1) begin
      if (op == 3'd0) return pack(1'b0, oh, ry, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      if (op == 3'd1) return pack(1'b0, oh, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      if (is_alu_op(op)) return pack(1'b0, 8'h00, rx, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      return pack(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    end
    if (k == 2) return pack(1'b0, 8'h00, ry, 1'b0, 1'b0, 1'b0, 1'b1, aop, 1'b0);
    return pack(1'b0, oh, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
  endfunction

  function automatic logic [127:0] flat(input logic [15:0] r [8]);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = r[i];
    return v;
  endfunction

  // Apply one cycle of the datapath using the DUT controls as seen just before the edge.
  task automatic commit();
    logic [15:0] bus;
    bus = din_en ? din : (gout ? dp_g : dp_r[r_out]);
    if (g_in) dp_g = alu(dp_a, bus, alu_op);
    if (a_in) dp_a = bus;
    for (int i = 0; i < 8; i++) if (r_in[i]) dp_r[i] = bus;
  endtask

  task automatic check_vec(input logic [18:0] e, input string tag);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: controls observed %h expected %h", tag, obs, e);
    end
  endtask

  // One clock: drive inputs, check controls and bus invariants, update datapath, advance.
  task automatic step(input logic r, input logic [15:0] d, input logic [18:0] e, input string tag);
    logic inv;
    run = r;
    din = d;
    #1;
    check_vec(e, tag);
    inv = !(din_en && gout) && !((din_en || gout) && (r_out != 3'd0)) && $onehot0(r_in);
    tests++;
    assert (inv === 1'b1) else begin
      fails++;
      $error("FAIL %s_invariant: observed %b expected 1", tag, inv);
    end
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), '0, "idle");
  endtask

  // Issue one instruction; run after the fetch cycle is random unless held high.
  task automatic run_instr(input logic [8:0] ins, input logic [15:0] imm, input bit hold);
    logic [15:0] d;
    logic [15:0] res;
    logic        r;
    logic [2:0]  op;
    op = ins[8:6];
    for (int k = 0; k < n_cycles(ins); k++) begin
      d = 16'($urandom);
      if (k == 0) d[8:0] = ins;
      else if (k == 1 && op == 3'd1) d = imm;
      r = (k == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom));
      step(r, d, expect_at(ins, k), $sformatf("ins%03h_c%0d", ins, k));
    end
    res = mref[ins[5:3]];
    if (op == 3'd0) res = mref[ins[2:0]];
    else if (op == 3'd1) res = imm;
    else if (is_alu_op(op)) res = alu(mref[ins[5:3]], mref[ins[2:0]], 2'(op - 3'd2));
    mref[ins[5:3]] = res;
    tests++;
    assert (flat(dp_r) === flat(mref)) else begin
      fails++;
      $error("FAIL regs_after_%03h: observed %h expected %h", ins, flat(dp_r), flat(mref));
    end
  endtask

  initial begin
    logic [8:0] rins;
    for (int i = 0; i < 8; i++) begin
      dp_r[i] = '0;
      mref[i] = '0;
    end
    dp_a   = '0;
    dp_g   = '0;
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;

    // Reset state: all controls idle while held in reset.
    #2;
    check_vec('0, "reset_hold");
    @(posedge clk);
    #1;
    check_vec('0, "reset_hold_edge");
    resetn = 1'b1;
    idle(2);

    // mvi r2,#0x1234 then mv r5,r2.
    run_instr(9'h050, 16'h1234, 1'b0);
    run_instr(9'h02A, 16'h0000, 1'b0);
    // add r0,r1 with r0=1, r1=2.
    run_instr(9'h040, 16'h0001, 1'b0);
    run_instr(9'h048, 16'h0002, 1'b0);
    run_instr(9'h081, 16'h0000, 1'b0);
    // add r3,r3 doubles; then sub r3,r3 and mv r4,r3 back to back with run held high.
    run_instr(9'h058, 16'h0007, 1'b1);
    run_instr(9'h09B, 16'h0000, 1'b1);
    run_instr(9'h0DB, 16'h0000, 1'b1);
    run_instr(9'h023, 16'h0000, 1'b1);
    idle(1);
    // Opcode 100 / 101 and the remaining NOP opcodes.
    run_instr(9'h10A, 16'h0000, 1'b0);
    run_instr(9'h153, 16'h0000, 1'b0);
    run_instr(9'h1C0, 16'h0000, 1'b0);

    // Reset in T2 of add r1,r0: abort with no register write and no done.
    step(1'b1, 16'h0088, expect_at(9'h088, 0), "abort_c0");
    step(1'b0, 16'h0000, expect_at(9'h088, 1), "abort_c1");
    run = 1'b0;
    #1;
    check_vec(expect_at(9'h088, 2), "abort_t2");
    resetn = 1'b0;
    #1;
    check_vec('0, "abort_reset_async");
    @(posedge clk);
    #1;
    check_vec('0, "abort_reset_edge");
    resetn = 1'b1;
    idle(3);
    tests++;
    assert (flat(dp_r) === flat(mref)) else begin
      fails++;
      $error("FAIL regs_after_abort: observed %h expected %h", flat(dp_r), flat(mref));
    end

    // Random instruction stream with random idle gaps and run holding.
    for (int n = 0; n < 120; n++) begin
      rins = 9'($urandom);
      run_instr(rins, 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
